// File: rtl/kvs_cmd_pkg.sv
// Shared types for the kvs command driver: operation encoding and op-class helpers.
package kvs_cmd_pkg;

    typedef enum logic [1:0] {
        OP_INSERT = 2'd0,
        OP_LOOKUP = 2'd1,
        OP_UPDATE = 2'd2,
        OP_DELETE = 2'd3
    } kvs_op_t;

    // UPDATE and DELETE both follow their lookup with a modify cycle.
    function automatic logic is_modify_op(input kvs_op_t op);
        return (op == OP_UPDATE) || (op == OP_DELETE);
    endfunction

    function automatic int unsigned rsp_bits(input int unsigned val_bits);
        return 3 + val_bits;
    endfunction

endpackage

// File: rtl/kvs_rsp_fifo.sv
// Small synchronous FIFO holding responses; head is readable in the same cycle it becomes valid.
module kvs_rsp_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       not_empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_rd;

    assign do_rd     = rd_en && (count_reg != '0);
    assign rd_data   = mem[rd_ptr_reg];
    assign not_empty = (count_reg != '0);
    assign count     = count_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({wr_en, do_rd})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Credits upstream make a write into a full FIFO unreachable.
    always @(posedge clk) begin
        if (rst_n && wr_en && !do_rd) begin
            assert (count_reg < CW'(DEPTH));
        end
    end

endmodule

// File: rtl/kvs_cmd_driver.sv
// Drives the kvs insert and lookup/modify ports from a command stream and returns one
// in-order response per command.
module kvs_cmd_driver
    import kvs_cmd_pkg::*;
#(
    parameter int KEY_BITS   = 32,
    parameter int VAL_BITS   = 32,
    parameter int LOOKUP_LAT = 3,
    parameter int RSP_DEPTH  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [KEY_BITS-1:0] cmd_key,
    input  logic [VAL_BITS-1:0] cmd_value,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [1:0]          rsp_op,
    output logic                rsp_found,
    output logic [VAL_BITS-1:0] rsp_value,
    output logic                kvs_insert,
    input  logic                kvs_busy,
    output logic [KEY_BITS-1:0] kvs_ins_key,
    output logic [VAL_BITS-1:0] kvs_ins_value,
    output logic                kvs_lookup,
    output logic [KEY_BITS-1:0] kvs_key,
    output logic                kvs_modify,
    output logic                kvs_del,
    output logic [VAL_BITS-1:0] kvs_mod_value,
    input  logic                kvs_valid,
    input  logic [VAL_BITS-1:0] kvs_value
);

    typedef struct packed {
        kvs_op_t             op;
        logic                found;
        logic [VAL_BITS-1:0] value;
    } rsp_t;

    localparam int TAGS = LOOKUP_LAT + 1;
    localparam int CW   = $clog2(RSP_DEPTH + 1);
    localparam int IW   = $clog2(TAGS + 1);

    kvs_op_t             cur_op;
    logic                fire;
    logic                credit_ok;
    logic                ins_block;
    logic                hazard;
    logic [IW-1:0]       inflight;
    logic [CW-1:0]       fifo_count;
    logic                fifo_not_empty;
    rsp_t                wr_rsp;
    rsp_t                rd_rsp;

    logic                run_reg;
    logic                ins_hold_reg;
    logic                hz_vld_reg;
    logic [KEY_BITS-1:0] hz_key_reg;
    kvs_op_t             iss_op_reg;
    logic [VAL_BITS-1:0] iss_value_reg;
    logic                kvs_insert_reg;
    logic [KEY_BITS-1:0] kvs_ins_key_reg;
    logic [VAL_BITS-1:0] kvs_ins_value_reg;
    logic                kvs_lookup_reg;
    logic [KEY_BITS-1:0] kvs_key_reg;
    logic                kvs_modify_reg;
    logic                kvs_del_reg;
    logic [VAL_BITS-1:0] kvs_mod_value_reg;
    logic [TAGS-1:0]     tag_vld_reg;
    kvs_op_t             tag_op_reg [TAGS];

    assign cur_op    = kvs_op_t'(cmd_op);
    assign inflight  = IW'($countones(tag_vld_reg));
    assign credit_ok = (32'(fifo_count) + 32'(inflight)) < 32'(RSP_DEPTH);
    assign ins_block = (cur_op == OP_INSERT) && (kvs_busy || ins_hold_reg);
    // A lookup right behind a same-key modify would read the value before the modify lands.
    assign hazard    = hz_vld_reg && (hz_key_reg == cmd_key);
    assign cmd_ready = run_reg && credit_ok && !ins_block && !hazard;
    assign fire      = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg           <= 1'b0;
            ins_hold_reg      <= 1'b0;
            hz_vld_reg        <= 1'b0;
            hz_key_reg        <= '0;
            iss_op_reg        <= OP_INSERT;
            iss_value_reg     <= '0;
            kvs_insert_reg    <= 1'b0;
            kvs_ins_key_reg   <= '0;
            kvs_ins_value_reg <= '0;
            kvs_lookup_reg    <= 1'b0;
            kvs_key_reg       <= '0;
            kvs_modify_reg    <= 1'b0;
            kvs_del_reg       <= 1'b0;
            kvs_mod_value_reg <= '0;
        end else begin
            run_reg        <= 1'b1;
            kvs_insert_reg <= fire && (cur_op == OP_INSERT);
            kvs_lookup_reg <= fire && (cur_op != OP_INSERT);
            ins_hold_reg   <= fire && (cur_op == OP_INSERT);
            hz_vld_reg     <= fire && is_modify_op(cur_op);
            if (fire) begin
                hz_key_reg <= cmd_key;
            end
            if (fire && cur_op == OP_INSERT) begin
                kvs_ins_key_reg   <= cmd_key;
                kvs_ins_value_reg <= cmd_value;
            end
            if (fire && cur_op != OP_INSERT) begin
                kvs_key_reg   <= cmd_key;
                iss_op_reg    <= cur_op;
                iss_value_reg <= cmd_value;
            end
            // Modify stage trails the lookup by exactly one cycle.
            kvs_modify_reg <= kvs_lookup_reg && is_modify_op(iss_op_reg);
            kvs_del_reg    <= kvs_lookup_reg && (iss_op_reg == OP_DELETE);
            if (kvs_lookup_reg && iss_op_reg == OP_UPDATE) begin
                kvs_mod_value_reg <= iss_value_reg;
            end
        end
    end

    // Tag pipe: the last stage lines up with the cycle the kvs result is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_reg <= '0;
            for (int i = 0; i < TAGS; i++) begin
                tag_op_reg[i] <= OP_INSERT;
            end
        end else begin
            tag_vld_reg   <= {tag_vld_reg[TAGS-2:0], fire};
            tag_op_reg[0] <= cur_op;
            for (int i = 1; i < TAGS; i++) begin
                tag_op_reg[i] <= tag_op_reg[i-1];
            end
        end
    end

    always_comb begin
        wr_rsp.op    = tag_op_reg[TAGS-1];
        wr_rsp.found = 1'b0;
        wr_rsp.value = '0;
        if (tag_op_reg[TAGS-1] != OP_INSERT && kvs_valid) begin
            wr_rsp.found = 1'b1;
            wr_rsp.value = kvs_value;
        end
    end

    kvs_rsp_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (tag_vld_reg[TAGS-1]),
        .wr_data   (wr_rsp),
        .rd_en     (rsp_ready),
        .rd_data   (rd_rsp),
        .not_empty (fifo_not_empty),
        .count     (fifo_count)
    );

    assign rsp_valid     = fifo_not_empty;
    assign rsp_op        = rd_rsp.op;
    assign rsp_found     = rd_rsp.found;
    assign rsp_value     = rd_rsp.value;

    assign kvs_insert    = kvs_insert_reg;
    assign kvs_ins_key   = kvs_ins_key_reg;
    assign kvs_ins_value = kvs_ins_value_reg;
    assign kvs_lookup    = kvs_lookup_reg;
    assign kvs_key       = kvs_key_reg;
    assign kvs_modify    = kvs_modify_reg;
    assign kvs_del       = kvs_del_reg;
    assign kvs_mod_value = kvs_mod_value_reg;

endmodule

// File: tb/tb_kvs_cmd_driver.sv
// Bench for kvs_cmd_driver: pin-level kvs model plus a command-level reference map.
module tb_kvs_cmd_driver;
    import kvs_cmd_pkg::*;

    localparam int KB    = 32;
    localparam int VB    = 32;
    localparam int LAT   = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [KB-1:0] cmd_key = '0;
    logic [VB-1:0] cmd_value = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [1:0]    rsp_op;
    logic          rsp_found;
    logic [VB-1:0] rsp_value;
    logic          kvs_insert;
    logic          kvs_busy = 1'b0;
    logic [KB-1:0] kvs_ins_key;
    logic [VB-1:0] kvs_ins_value;
    logic          kvs_lookup;
    logic [KB-1:0] kvs_key;
    logic          kvs_modify;
    logic          kvs_del;
    logic [VB-1:0] kvs_mod_value;
    logic          kvs_valid;
    logic [VB-1:0] kvs_value;

    kvs_cmd_driver #(
        .KEY_BITS(KB), .VAL_BITS(VB), .LOOKUP_LAT(LAT), .RSP_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_key(cmd_key), .cmd_value(cmd_value),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
        .rsp_found(rsp_found), .rsp_value(rsp_value),
        .kvs_insert(kvs_insert), .kvs_busy(kvs_busy), .kvs_ins_key(kvs_ins_key),
        .kvs_ins_value(kvs_ins_value), .kvs_lookup(kvs_lookup), .kvs_key(kvs_key),
        .kvs_modify(kvs_modify), .kvs_del(kvs_del), .kvs_mod_value(kvs_mod_value),
        .kvs_valid(kvs_valid), .kvs_value(kvs_value)
    );

    always #5 clk = ~clk;

    // Pin-level kvs: lookup reads the store, modify applies one cycle later, result after LAT.
    logic [VB-1:0] kv_mem [logic [KB-1:0]];
    logic          pv_vld [LAT] = '{default: 1'b0};
    logic [VB-1:0] pv_val [LAT] = '{default: '0};
    logic [KB-1:0] mod_key = '0;

    always @(posedge clk) begin
        if (kvs_lookup && kv_mem.exists(kvs_key) != 0) begin
            pv_vld[0] <= 1'b1;
            pv_val[0] <= kv_mem[kvs_key];
        end else begin
            pv_vld[0] <= 1'b0;
            pv_val[0] <= $urandom;
        end
        for (int i = 1; i < LAT; i++) begin
            pv_vld[i] <= pv_vld[i-1];
            pv_val[i] <= pv_val[i-1];
        end
        mod_key <= kvs_key;
        if (kvs_modify && kv_mem.exists(mod_key) != 0) begin
            if (kvs_del) kv_mem.delete(mod_key);
            else         kv_mem[mod_key] = kvs_mod_value;
        end
        if (kvs_insert) kv_mem[kvs_ins_key] = kvs_ins_value;
    end

    assign kvs_valid = pv_vld[LAT-1];
    assign kvs_value = pv_val[LAT-1];

    // Monitors record timing and responses; only the main block judges them.
    typedef struct {
        logic [1:0]    op;
        logic          found;
        logic [VB-1:0] value;
        int            cyc;
    } got_t;

    typedef struct packed {
        logic [1:0]    op;
        logic          found;
        logic [VB-1:0] value;
    } exp_t;

    got_t            got_q[$];
    int              cyc = 0;
    int              acc_cyc = -1;
    int              md_cyc = -1;
    int              ins_cnt = 0;
    int              ins_last = -100;
    int              ins_prev = -200;
    int              ins_viol = 0;
    int              stab_viol = 0;
    logic            md_del = 1'b0;
    logic [VB-1:0]   md_val = '0;
    logic            busy_d = 1'b0;
    logic            prev_stall = 1'b0;
    logic [VB+2:0]   prev_rsp = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && cmd_valid && cmd_ready) acc_cyc <= cyc;
        if (kvs_modify) begin
            md_cyc <= cyc;
            md_del <= kvs_del;
            md_val <= kvs_mod_value;
        end
        if (kvs_insert) begin
            ins_cnt  <= ins_cnt + 1;
            ins_prev <= ins_last;
            ins_last <= cyc;
            if (busy_d) ins_viol <= ins_viol + 1;
        end
        busy_d <= kvs_busy;
        if (rst_n && prev_stall && (!rsp_valid || {rsp_op, rsp_found, rsp_value} != prev_rsp))
            stab_viol <= stab_viol + 1;
        prev_stall <= rst_n && rsp_valid && !rsp_ready;
        prev_rsp   <= {rsp_op, rsp_found, rsp_value};
        if (rst_n && rsp_valid && rsp_ready) got_q.push_back('{rsp_op, rsp_found, rsp_value, cyc});
    end

    int            checks = 0;
    int            failures = 0;
    int            got_rd = 0;
    int            last_rsp_cyc = -1;
    exp_t          exp_q[$];
    logic [VB-1:0] ref_mem [logic [KB-1:0]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Command-level semantics: each command sees the effect of every earlier one.
    task automatic ref_cmd(input kvs_op_t op, input logic [KB-1:0] k, input logic [VB-1:0] v);
        exp_t e;
        e.op = op; e.found = 1'b0; e.value = '0;
        if (op == OP_INSERT) begin
            ref_mem[k] = v;
        end else if (ref_mem.exists(k) != 0) begin
            e.found = 1'b1;
            e.value = ref_mem[k];
            if (op == OP_UPDATE)      ref_mem[k] = v;
            else if (op == OP_DELETE) ref_mem.delete(k);
        end
        exp_q.push_back(e);
    endtask

    task automatic drive(input kvs_op_t op, input logic [KB-1:0] k, input logic [VB-1:0] v,
                         input bit rnd, input int lim, output bit ok);
        cmd_valid = 1'b1; cmd_op = op; cmd_key = k; cmd_value = v;
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            if (rnd) begin
                rsp_ready = ($urandom_range(3) != 0);
                kvs_busy  = ($urandom_range(3) == 0);
            end
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (ok) ref_cmd(op, k, v);
    endtask

    task automatic send(input string tag, input kvs_op_t op, input logic [KB-1:0] k,
                        input logic [VB-1:0] v);
        bit ok;
        drive(op, k, v, 1'b0, 100, ok);
        check({tag, "_accept"}, 64'(ok), 64'(1));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        rsp_ready = 1'b1;
        kvs_busy  = 1'b0;
        while ((got_q.size() - got_rd) < exp_q.size() && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_count"}, 64'(got_q.size() - got_rd), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_rd < got_q.size()) begin
            exp_t e;
            got_t g;
            e = exp_q.pop_front();
            g = got_q[got_rd];
            got_rd++;
            check(tag, 64'({g.op, g.found, g.value}), 64'(e));
            $display("rsp %s op=%0d found=%0d value=%0h cyc=%0d", tag, g.op, g.found, g.value, g.cyc);
            last_rsp_cyc = g.cyc;
        end
        exp_q.delete();
    endtask

    initial begin
        int  a_ins, a_lk, a_up, a_del, b0, n_acc, ins0;
        bit  ok, bad;
        logic [KB-1:0] k;
        kvs_op_t op;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_kvs_ctl", 64'({kvs_insert, kvs_lookup, kvs_modify, kvs_del}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: INSERT then LOOKUP
        ins0 = ins_cnt;
        send("t1_ins", OP_INSERT, 32'h10, 32'hAA);
        a_ins = acc_cyc;
        send("t1_lk", OP_LOOKUP, 32'h10, 32'h0);
        a_lk = acc_cyc;
        drain("t1_rsp");
        check("t1_ins_pulses", 64'(ins_cnt - ins0), 64'(1));
        check("t1_ins_time", 64'(ins_last), 64'(a_ins + 1));
        check("t1_latency", 64'(last_rsp_cyc), 64'(a_lk + LAT + 2));

        // 2: UPDATE then same-key LOOKUP needs one bubble
        send("t2_up", OP_UPDATE, 32'h10, 32'hBB);
        a_up = acc_cyc;
        send("t2_lk", OP_LOOKUP, 32'h10, 32'h0);
        a_lk = acc_cyc;
        check("t2_bubble", 64'(a_lk - a_up), 64'(2));
        check("t2_mod_time", 64'(md_cyc), 64'(a_up + 2));
        check("t2_mod_ctl", 64'({md_del, md_val}), 64'({1'b0, 32'hBB}));
        drain("t2_rsp");

        // Throughput: distinct keys stream without gaps
        send("tp_ins", OP_INSERT, 32'h11, 32'h5);
        send("tp_up", OP_UPDATE, 32'h11, 32'h6);
        a_up = acc_cyc;
        send("tp_lk1", OP_LOOKUP, 32'h12, 32'h0);
        check("tp_no_bubble", 64'(acc_cyc - a_up), 64'(1));
        send("tp_lk2", OP_LOOKUP, 32'h11, 32'h0);
        send("tp_lk3", OP_DELETE, 32'h13, 32'h0);
        check("tp_back2back", 64'(acc_cyc - a_up), 64'(3));
        drain("tp_rsp");

        // 3: DELETE then LOOKUP
        send("t3_del", OP_DELETE, 32'h10, 32'h0);
        a_del = acc_cyc;
        send("t3_lk", OP_LOOKUP, 32'h10, 32'h0);
        check("t3_mod_time", 64'(md_cyc), 64'(a_del + 2));
        check("t3_del_flag", 64'(md_del), 64'(1));
        drain("t3_rsp");

        // 4: busy holds an INSERT; back-to-back INSERTs spaced
        ins0 = ins_cnt;
        kvs_busy = 1'b1;
        cmd_valid = 1'b1; cmd_op = OP_INSERT; cmd_key = 32'h20; cmd_value = 32'hC0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bad = bad | cmd_ready | kvs_insert;
            @(posedge clk); #1;
        end
        check("t4_busy_stall", 64'(bad), 64'(0));
        kvs_busy = 1'b0;
        b0 = cyc;
        send("t4_ins1", OP_INSERT, 32'h20, 32'hC0);
        check("t4_release", 64'(acc_cyc), 64'(b0));
        send("t4_ins2", OP_INSERT, 32'h21, 32'hC1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t4_ins_pulses", 64'(ins_cnt - ins0), 64'(2));
        check("t4_spacing_ge2", 64'((ins_last - ins_prev) >= 2), 64'(1));
        drain("t4_rsp");

        // Randomized mix over a small key set so hazards and busy stalls occur
        for (int i = 0; i < 60; i++) begin
            op = kvs_op_t'($urandom_range(3));
            k  = 32'h20 + 32'($urandom_range(3));
            drive(op, k, $urandom, 1'b1, 100, ok);
            check("rnd_accept", 64'(ok), 64'(1));
        end
        drain("rnd_rsp");

        // 5: rsp_ready low, stream LOOKUPs until credits run out
        rsp_ready = 1'b0;
        n_acc = 0;
        ok = 1'b1;
        while (ok && n_acc < 20) begin
            drive(OP_LOOKUP, 32'h20 + 32'($urandom_range(3)), 32'h0, 1'b0, 12, ok);
            if (ok) n_acc++;
        end
        check("t5_accepted", 64'(n_acc), 64'(DEPTH));
        check("t5_no_rsp", 64'(got_q.size() - got_rd), 64'(0));
        rsp_ready = 1'b1;
        while (n_acc < 20) begin
            send("t5_rest", OP_LOOKUP, 32'h20 + 32'($urandom_range(3)), 32'h0);
            n_acc++;
        end
        drain("t5_rsp");

        // 6: reset with lookups in flight
        send("t6_lk", OP_LOOKUP, 32'h20, 32'h0);
        send("t6_lk", OP_LOOKUP, 32'h21, 32'h0);
        send("t6_lk", OP_LOOKUP, 32'h22, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_ctl", 64'({cmd_ready, rsp_valid, kvs_insert, kvs_lookup, kvs_modify, kvs_del}), 64'(0));
        exp_q.delete();
        got_rd = got_q.size();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("t6_no_stale", 64'(got_q.size() - got_rd), 64'(0));
        send("t6_fresh", OP_LOOKUP, 32'h20, 32'h0);
        drain("t6_rsp");

        repeat (10) @(posedge clk);
        #1;
        check("end_no_extra", 64'(got_q.size() - got_rd), 64'(0));
        check("ins_while_busy", 64'(ins_viol), 64'(0));
        check("rsp_stable", 64'(stab_viol), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
